// File: rtl/controle_fluxo_pc.sv
// Control-flow sequencer for the stack CPU program counter: fetch/decode/execute loop,
// one-hot PC strobes and the CALL/RET return-address stack.
module controle_fluxo_pc #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int RS_DEPTH   = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        run,
    input  logic [DATA_WIDTH-1:0]       instr,
    input  logic [ADDR_WIDTH-1:0]       pc_value,
    input  logic                        t_zero,
    input  logic                        es_busy,
    output logic                        instr_read,
    output logic                        pc_step,
    output logic                        pc_branch,
    output logic                        pc_return,
    output logic                        pc_hold,
    output logic [10:0]                 pc_offset,
    output logic [ADDR_WIDTH-1:0]       ret_addr,
    output logic                        alu_en,
    output logic [4:0]                  alu_op,
    output logic [$clog2(RS_DEPTH):0]   rs_count,
    output logic                        halted,
    output logic                        stack_err
);

    localparam int PTR_W = $clog2(RS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_JMP  = 5'b00001;
    localparam logic [4:0] OP_JZ   = 5'b00010;
    localparam logic [4:0] OP_CALL = 5'b00011;
    localparam logic [4:0] OP_RET  = 5'b00100;
    localparam logic [4:0] OP_HALT = 5'b00101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WAIT_ES,
        S_HALT,
        S_FAULT
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   ir_q, ir_d;
    logic                    instr_read_q, instr_read_d;
    logic                    pc_step_q, pc_step_d;
    logic                    pc_branch_q, pc_branch_d;
    logic                    pc_return_q, pc_return_d;
    logic                    pc_hold_q, pc_hold_d;
    logic                    alu_en_q, alu_en_d;
    logic                    halted_q, halted_d;
    logic                    stack_err_q, stack_err_d;
    logic [10:0]             pc_offset_q, pc_offset_d;
    logic [ADDR_WIDTH-1:0]   ret_addr_q, ret_addr_d;
    logic [4:0]              alu_op_q, alu_op_d;
    logic [CNT_W-1:0]        rs_count_q, rs_count_d;

    logic [ADDR_WIDTH-1:0]   stack_q [RS_DEPTH];
    logic                    push_en;
    logic [ADDR_WIDTH-1:0]   push_data;
    logic [PTR_W-1:0]        push_ptr;
    logic [PTR_W-1:0]        top_ptr;
    logic                    rs_full;
    logic                    rs_empty;
    logic [4:0]              opcode;

    assign opcode    = ir_q[15:11];
    assign push_data = pc_value + ADDR_WIDTH'(1);
    assign push_ptr  = rs_count_q[PTR_W-1:0];
    assign top_ptr   = PTR_W'(rs_count_q - CNT_W'(1));
    assign rs_full   = (rs_count_q == CNT_W'(RS_DEPTH));
    assign rs_empty  = (rs_count_q == '0);

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        instr_read_d = 1'b0;
        pc_step_d    = 1'b0;
        pc_branch_d  = 1'b0;
        pc_return_d  = 1'b0;
        pc_hold_d    = 1'b0;
        alu_en_d     = 1'b0;
        halted_d     = 1'b0;
        stack_err_d  = stack_err_q;
        pc_offset_d  = pc_offset_q;
        ret_addr_d   = ret_addr_q;
        alu_op_d     = alu_op_q;
        rs_count_d   = rs_count_q;
        push_en      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = instr;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (es_busy) begin
                    pc_hold_d = 1'b1;
                    state_d   = S_WAIT_ES;
                end else begin
                    state_d     = S_FETCH;
                    pc_offset_d = ir_q[10:0];
                    case (opcode)
                        OP_NOP: pc_step_d = 1'b1;
                        OP_JMP: pc_branch_d = 1'b1;
                        OP_JZ: begin
                            if (t_zero) begin
                                pc_branch_d = 1'b1;
                            end else begin
                                pc_step_d = 1'b1;
                            end
                        end
                        OP_CALL: begin
                            // A full stack faults without touching its contents
                            if (rs_full) begin
                                pc_hold_d = 1'b1;
                                state_d   = S_FAULT;
                            end else begin
                                push_en     = 1'b1;
                                rs_count_d  = rs_count_q + CNT_W'(1);
                                pc_branch_d = 1'b1;
                            end
                        end
                        OP_RET: begin
                            if (rs_empty) begin
                                pc_hold_d = 1'b1;
                                state_d   = S_FAULT;
                            end else begin
                                ret_addr_d  = stack_q[top_ptr];
                                rs_count_d  = rs_count_q - CNT_W'(1);
                                pc_return_d = 1'b1;
                            end
                        end
                        OP_HALT: begin
                            pc_hold_d = 1'b1;
                            state_d   = S_HALT;
                        end
                        default: begin
                            alu_en_d  = 1'b1;
                            alu_op_d  = opcode;
                            pc_step_d = 1'b1;
                        end
                    endcase
                end
            end
            S_WAIT_ES: begin
                // Instruction stays in ir_q; it re-executes without a new fetch
                pc_hold_d = es_busy;
                if (!es_busy) begin
                    state_d = S_EXEC;
                end
            end
            S_HALT: begin
                halted_d  = 1'b1;
                pc_hold_d = 1'b1;
            end
            S_FAULT: begin
                stack_err_d = 1'b1;
                pc_hold_d   = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        instr_read_d = (state_d == S_FETCH);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            instr_read_q <= 1'b0;
            pc_step_q    <= 1'b0;
            pc_branch_q  <= 1'b0;
            pc_return_q  <= 1'b0;
            pc_hold_q    <= 1'b0;
            alu_en_q     <= 1'b0;
            halted_q     <= 1'b0;
            stack_err_q  <= 1'b0;
            pc_offset_q  <= '0;
            ret_addr_q   <= '0;
            alu_op_q     <= '0;
            rs_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            instr_read_q <= instr_read_d;
            pc_step_q    <= pc_step_d;
            pc_branch_q  <= pc_branch_d;
            pc_return_q  <= pc_return_d;
            pc_hold_q    <= pc_hold_d;
            alu_en_q     <= alu_en_d;
            halted_q     <= halted_d;
            stack_err_q  <= stack_err_d;
            pc_offset_q  <= pc_offset_d;
            ret_addr_q   <= ret_addr_d;
            alu_op_q     <= alu_op_d;
            rs_count_q   <= rs_count_d;
        end
    end

    // Instruction register and stack storage carry data only; no reset needed
    always_ff @(posedge clock) begin
        ir_q <= ir_d;
        if (push_en && !reset) begin
            stack_q[push_ptr] <= push_data;
        end
    end

    assign instr_read = instr_read_q;
    assign pc_step    = pc_step_q;
    assign pc_branch  = pc_branch_q;
    assign pc_return  = pc_return_q;
    assign pc_hold    = pc_hold_q;
    assign pc_offset  = pc_offset_q;
    assign ret_addr   = ret_addr_q;
    assign alu_en     = alu_en_q;
    assign alu_op     = alu_op_q;
    assign rs_count   = rs_count_q;
    assign halted     = halted_q;
    assign stack_err  = stack_err_q;

endmodule

// File: tb/tb_controle_fluxo_pc.sv
// Directed bench for controle_fluxo_pc: instruction sequencing, branches, return stack,
// E/S stalls, HALT and stack faults.
module tb_controle_fluxo_pc;

    logic        clock;
    logic        reset;
    logic        run;
    logic [15:0] instr;
    logic [15:0] pc_value;
    logic        t_zero;
    logic        es_busy;
    logic        instr_read;
    logic        pc_step;
    logic        pc_branch;
    logic        pc_return;
    logic        pc_hold;
    logic [10:0] pc_offset;
    logic [15:0] ret_addr;
    logic        alu_en;
    logic [4:0]  alu_op;
    logic [3:0]  rs_count;
    logic        halted;
    logic        stack_err;

    int checks = 0;
    int errors = 0;

    // Strobe vector order: {instr_read, pc_step, pc_branch, pc_return, pc_hold, alu_en, halted, stack_err}
    localparam logic [7:0] ST_NONE   = 8'b0000_0000;
    localparam logic [7:0] ST_FETCH  = 8'b1000_0000;
    localparam logic [7:0] ST_STEP   = 8'b1100_0000;
    localparam logic [7:0] ST_BRANCH = 8'b1010_0000;
    localparam logic [7:0] ST_RETURN = 8'b1001_0000;
    localparam logic [7:0] ST_HOLD   = 8'b0000_1000;
    localparam logic [7:0] ST_ALU    = 8'b1100_0100;
    localparam logic [7:0] ST_HALTED = 8'b0000_1010;
    localparam logic [7:0] ST_FAULT  = 8'b0000_1001;

    controle_fluxo_pc #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(16),
        .RS_DEPTH  (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .instr     (instr),
        .pc_value  (pc_value),
        .t_zero    (t_zero),
        .es_busy   (es_busy),
        .instr_read(instr_read),
        .pc_step   (pc_step),
        .pc_branch (pc_branch),
        .pc_return (pc_return),
        .pc_hold   (pc_hold),
        .pc_offset (pc_offset),
        .ret_addr  (ret_addr),
        .alu_en    (alu_en),
        .alu_op    (alu_op),
        .rs_count  (rs_count),
        .halted    (halted),
        .stack_err (stack_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] strobes();
        return {instr_read, pc_step, pc_branch, pc_return, pc_hold, alu_en, halted, stack_err};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        run      = 1'b0;
        es_busy  = 1'b0;
        t_zero   = 1'b0;
        pc_value = 16'h0000;
        instr    = 16'h0000;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Leaves the sequencer in FETCH with the first instr_read visible
    task automatic start_run();
        run = 1'b1;
        tick();
        chk("start_fetch", 32'(strobes()), 32'(ST_FETCH));
    endtask

    // Entered in FETCH; returns after the EXEC edge with its strobes visible
    task automatic exec_instr(input string tag, input logic [15:0] w,
                              input logic [15:0] pc, input logic tz);
        instr = w;
        tick();
        chk({tag, "_dec_quiet"}, 32'(strobes()), 32'(ST_NONE));
        tick();
        chk({tag, "_exe_quiet"}, 32'(strobes()), 32'(ST_NONE));
        pc_value = pc;
        t_zero   = tz;
        tick();
    endtask

    initial begin
        do_reset();
        chk("rst_strobes", 32'(strobes()), 32'(ST_NONE));
        chk("rst_rs_count", 32'(rs_count), 32'd0);
        chk("rst_pc_offset", 32'(pc_offset), 32'd0);
        chk("rst_ret_addr", 32'(ret_addr), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);

        // NOP stream: fetch every third cycle, one pc_step per instruction
        start_run();
        for (int i = 0; i < 3; i++) begin
            exec_instr("nop", 16'h0000, 16'h0000, 1'b0);
            chk("nop_step", 32'(strobes()), 32'(ST_STEP));
        end

        // JZ / JMP
        exec_instr("jz1", 16'h1005, 16'h0000, 1'b1);
        chk("jz_taken", 32'(strobes()), 32'(ST_BRANCH));
        chk("jz_offset", 32'(pc_offset), 32'h005);
        exec_instr("jz0", 16'h1005, 16'h0000, 1'b0);
        chk("jz_not_taken", 32'(strobes()), 32'(ST_STEP));
        exec_instr("jmp", 16'h0923, 16'h0000, 1'b0);
        chk("jmp_branch", 32'(strobes()), 32'(ST_BRANCH));
        chk("jmp_offset", 32'(pc_offset), 32'h123);

        // CALL / RET, address wrap and LIFO order
        exec_instr("call10", 16'h1840, 16'h0010, 1'b0);
        chk("call10_strobe", 32'(strobes()), 32'(ST_BRANCH));
        chk("call10_rs", 32'(rs_count), 32'd1);
        chk("call10_offset", 32'(pc_offset), 32'h040);
        exec_instr("ret11", 16'h2000, 16'h0000, 1'b0);
        chk("ret11_strobe", 32'(strobes()), 32'(ST_RETURN));
        chk("ret11_addr", 32'(ret_addr), 32'h0011);
        chk("ret11_rs", 32'(rs_count), 32'd0);
        exec_instr("nop_hold", 16'h0000, 16'h0000, 1'b0);
        chk("ret_addr_held", 32'(ret_addr), 32'h0011);
        exec_instr("callff", 16'h1840, 16'hFFFF, 1'b0);
        chk("callff_rs", 32'(rs_count), 32'd1);
        exec_instr("ret00", 16'h2000, 16'h0000, 1'b0);
        chk("ret_wrap_addr", 32'(ret_addr), 32'h0000);
        exec_instr("callA", 16'h1840, 16'h0100, 1'b0);
        exec_instr("callB", 16'h1840, 16'h0200, 1'b0);
        chk("nested_rs", 32'(rs_count), 32'd2);
        exec_instr("retB", 16'h2000, 16'h0000, 1'b0);
        chk("retB_addr", 32'(ret_addr), 32'h0201);
        exec_instr("retA", 16'h2000, 16'h0000, 1'b0);
        chk("retA_addr", 32'(ret_addr), 32'h0101);
        chk("retA_rs", 32'(rs_count), 32'd0);

        // Plain ALU op
        exec_instr("alu1f", 16'hF800, 16'h0000, 1'b0);
        chk("alu1f_strobe", 32'(strobes()), 32'(ST_ALU));
        chk("alu1f_op", 32'(alu_op), 32'h1F);

        // ALU op stalled four cycles by the E/S unit
        instr = 16'h5000;
        tick();
        tick();
        es_busy = 1'b1;
        instr   = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_hold", 32'(strobes()), 32'(ST_HOLD));
        end
        es_busy = 1'b0;
        tick();
        chk("stall_release", 32'(strobes()), 32'(ST_NONE));
        tick();
        chk("stall_alu", 32'(strobes()), 32'(ST_ALU));
        chk("stall_alu_op", 32'(alu_op), 32'h0A);

        // HALT is terminal
        exec_instr("halt", 16'h2800, 16'h0000, 1'b0);
        chk("halt_enter", 32'(strobes()), 32'(ST_HOLD));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_stuck", 32'(strobes()), 32'(ST_HALTED));
        end

        // RET on an empty stack
        do_reset();
        start_run();
        exec_instr("ret_empty", 16'h2000, 16'h0000, 1'b0);
        chk("underflow_hold", 32'(strobes()), 32'(ST_HOLD));
        chk("underflow_rs", 32'(rs_count), 32'd0);
        tick();
        chk("underflow_fault", 32'(strobes()), 32'(ST_FAULT));
        tick();
        chk("underflow_sticky", 32'(strobes()), 32'(ST_FAULT));

        // RS_DEPTH+1 nested CALLs
        do_reset();
        start_run();
        for (int i = 0; i < 8; i++) begin
            exec_instr("deep_call", 16'h1801, 16'(i * 16), 1'b0);
            chk("deep_call_strobe", 32'(strobes()), 32'(ST_BRANCH));
            chk("deep_call_rs", 32'(rs_count), 32'(i + 1));
        end
        exec_instr("over_call", 16'h1801, 16'h0500, 1'b0);
        chk("overflow_hold", 32'(strobes()), 32'(ST_HOLD));
        chk("overflow_rs", 32'(rs_count), 32'd8);
        tick();
        chk("overflow_fault", 32'(strobes()), 32'(ST_FAULT));
        chk("overflow_rs_kept", 32'(rs_count), 32'd8);

        // Reset asserted while stalled in WAIT_ES
        do_reset();
        start_run();
        exec_instr("pre_alu", 16'h5000, 16'h0000, 1'b0);
        exec_instr("pre_call", 16'h18AA, 16'h0030, 1'b0);
        exec_instr("pre_ret", 16'h2055, 16'h0000, 1'b0);
        chk("pre_ret_addr", 32'(ret_addr), 32'h0031);
        exec_instr("pre_call2", 16'h18AA, 16'h0040, 1'b0);
        chk("pre_rs", 32'(rs_count), 32'd1);
        instr = 16'h5000;
        tick();
        tick();
        es_busy = 1'b1;
        tick();
        chk("wait_hold", 32'(strobes()), 32'(ST_HOLD));
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_strobes", 32'(strobes()), 32'(ST_NONE));
        chk("midrst_rs", 32'(rs_count), 32'd0);
        chk("midrst_offset", 32'(pc_offset), 32'd0);
        chk("midrst_ret_addr", 32'(ret_addr), 32'd0);
        chk("midrst_alu_op", 32'(alu_op), 32'd0);
        reset   = 1'b0;
        run     = 1'b0;
        es_busy = 1'b0;
        tick();
        chk("midrst_idle", 32'(strobes()), 32'(ST_NONE));
        run = 1'b1;
        tick();
        chk("midrst_restart", 32'(strobes()), 32'(ST_FETCH));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
